// File: rtl/player_input_pulser.sv
// Player key front end for the tug-of-war light chain.
// Turns the two raw active-low bouncing keys into clean debounced levels
// (heldL/heldR) and single-cycle press pulses (L/R). A press that lands on
// both keys in the same cycle is cancelled, and enable=0 swallows presses
// while the debounced levels keep tracking the keys.
module player_input_pulser #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic keyL_n,
  input  logic keyR_n,
  input  logic enable,
  output logic L,
  output logic R,
  output logic heldL,
  output logic heldR
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Channel index 0 is the left key, index 1 the right key.
  logic [1:0]         key_p0;   // first synchronizer stage (1 = pressed)
  logic [1:0]         key_p1;   // second synchronizer stage, the "s" level
  logic [1:0]         db;       // debounced level
  logic [1:0][CW-1:0] cnt;      // consecutive cycles s has disagreed with db
  logic [1:0]         accept;   // this edge adopts s as the new debounced level
  logic [1:0]         rise;     // this edge takes db from released to pressed

  // Two-flop synchronizer for the inverted (active-high) keys.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_p0 <= 2'b00;
      key_p1 <= 2'b00;
    end else begin
      key_p0 <= {~keyR_n, ~keyL_n};
      key_p1 <= key_p0;
    end
  end

  // A level is accepted on the edge that sees the DEBOUNCE_CYCLES-th
  // consecutive disagreement; only a 0->1 acceptance counts as a press.
  always_comb begin
    accept = 2'b00;
    rise   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      accept[i] = (key_p1[i] != db[i]) && (cnt[i] == CNT_LAST);
      rise[i]   = accept[i] & key_p1[i];
    end
  end

  // Debounce counter and level: any agreement clears the run, so glitches
  // shorter than the window never reach db.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db  <= 2'b00;
      cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (key_p1[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          db[i]  <= key_p1[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press pulses: simultaneous rises cancel and are not deferred; enable
  // gates only the pulses, never the debounce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      L <= 1'b0;
      R <= 1'b0;
    end else begin
      L <= rise[0] & ~rise[1] & enable;
      R <= rise[1] & ~rise[0] & enable;
    end
  end

  assign heldL = db[0];
  assign heldR = db[1];

endmodule

// File: tb/tb_player_input_pulser.sv
// Self-checking bench for player_input_pulser: directed scenarios with
// hand-computed timing, then randomized bouncing keys against a reference
// model that applies the rule "a level is accepted once the last
// DEBOUNCE_CYCLES synchronized samples all disagree with it".
module tb_player_input_pulser;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset, keyL_n, keyR_n, enable;
  logic L, R, heldL, heldR;

  player_input_pulser #(.DEBOUNCE_CYCLES(D)) dut (
    .clk    (clk),
    .reset  (reset),
    .keyL_n (keyL_n),
    .keyR_n (keyR_n),
    .enable (enable),
    .L      (L),
    .R      (R),
    .heldL  (heldL),
    .heldR  (heldR)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: raw pressed samples (index 0 newest), the
  // synchronized observations the debouncer has seen, and expected outputs.
  bit raw [2][3];
  bit obs [2][D];
  int nobs [2];
  bit mdb [2];
  bit mL, mR;

  // Scenario bookkeeping.
  int edge_n, gedge, nL, nR, lastL, lastR;
  bit prevL, prevR;
  int pe[$];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 3; i++) raw[c][i] = 1'b0;
      for (int i = 0; i < D; i++) obs[c][i] = 1'b0;
      nobs[c] = 0;
      mdb[c]  = 1'b0;
    end
    mL = 1'b0;
    mR = 1'b0;
  endtask

  task automatic model_edge(input bit kl_n, input bit kr_n, input bit en);
    bit pr [2];
    bit rs [2];
    bit s;
    bit all_diff;
    pr[0] = ~kl_n;
    pr[1] = ~kr_n;
    for (int c = 0; c < 2; c++) begin
      // The debouncer at this edge sees the key sampled two edges ago.
      raw[c][2] = raw[c][1];
      raw[c][1] = raw[c][0];
      raw[c][0] = pr[c];
      s = raw[c][2];
      for (int i = D - 1; i > 0; i--) obs[c][i] = obs[c][i-1];
      obs[c][0] = s;
      if (nobs[c] < D) nobs[c]++;
      all_diff = (nobs[c] == D);
      for (int i = 0; i < D; i++) if (obs[c][i] == mdb[c]) all_diff = 1'b0;
      rs[c] = 1'b0;
      if (all_diff) begin
        mdb[c] = ~mdb[c];
        rs[c]  = mdb[c];
      end
    end
    mL = rs[0] & ~rs[1] & en;
    mR = rs[1] & ~rs[0] & en;
  endtask

  task automatic clear_counts();
    edge_n = 0;
    nL = 0;
    nR = 0;
    lastL = -1;
    lastR = -1;
    pe.delete();
  endtask

  // One clock: drive inputs away from the edge, advance the model on the
  // edge, sample the DUT 1 time unit later.
  task automatic step(input bit kl_n, input bit kr_n, input bit en);
    keyL_n = kl_n;
    keyR_n = kr_n;
    enable = en;
    @(posedge clk);
    model_edge(kl_n, kr_n, en);
    #1;
    chk("L", L, mL);
    chk("R", R, mR);
    chk("heldL", heldL, mdb[0]);
    chk("heldR", heldR, mdb[1]);
    chk("L_R_excl", L & R, 0);
    chk("L_repeat", L & prevL, 0);
    chk("R_repeat", R & prevR, 0);
    prevL = L;
    prevR = R;
    if (L) begin nL++; lastL = edge_n; pe.push_back(gedge); end
    if (R) begin nR++; lastR = edge_n; end
    edge_n++;
    gedge++;
  endtask

  // Asynchronous reset placed between edges, held across one edge.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_L", L, 0);
    chk("rst_R", R, 0);
    chk("rst_heldL", heldL, 0);
    chk("rst_heldR", heldR, 0);
    model_reset();
    prevL = 1'b0;
    prevR = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    clear_counts();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lenL, lenR;
    bit lvL, lvR, en;
    reset  = 1'b0;
    keyL_n = 1'b1;
    keyR_n = 1'b1;
    enable = 1'b1;
    gedge  = 0;
    prevL  = 1'b0;
    prevR  = 1'b0;
    model_reset();
    #1;
    async_reset();

    // Clean left press held 20 cycles.
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 1'b1);
      chk("t1_heldL", heldL, (k >= 5));
      chk("t1_L", L, (k == 5));
    end
    chk("t1_nL", nL, 1);
    chk("t1_nR", nR, 0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b1);
    chk("t1_release", heldL, 0);

    // Bouncing right key; final stable low begins at edge 8.
    clear_counts();
    for (int k = 0; k < 18; k++) begin
      bit kr;
      kr = (k == 3 || k == 7);
      step(1'b1, kr, 1'b1);
    end
    chk("t2_nR", nR, 1);
    chk("t2_lastR", lastR, 13);
    chk("t2_nL", nL, 0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b1);

    // Simultaneous press cancels; a later lone press still pulses.
    clear_counts();
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, 1'b1);
      chk("t3_held_both", {heldL, heldR}, (k >= 5) ? 2'b11 : 2'b00);
    end
    chk("t3_nL", nL, 0);
    chk("t3_nR", nR, 0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b1);
    clear_counts();
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1);
    chk("t3_lone_nL", nL, 1);
    chk("t3_lone_lastL", lastL, 5);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b1);

    // Enable gating.
    clear_counts();
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0);
    chk("t4_held_dis", heldL, 1);
    chk("t4_nL_dis", nL, 0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1);
    chk("t4_nL_en_held", nL, 0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1);
    chk("t4_nL_repress", nL, 1);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b1);

    // Repeat rate: three presses, 8 low / 8 high each.
    clear_counts();
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b1);
    end
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b1);
    chk("t5_nL", nL, 3);
    if (pe.size() == 3) begin
      chk("t5_gap1", pe[1] - pe[0], 16);
      chk("t5_gap2", pe[2] - pe[1], 16);
    end else begin
      chk("t5_pulse_list", pe.size(), 3);
    end

    // Reset while L is mid-count (cnt=2 after edge 3), key still held.
    async_reset();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1);
    chk("t6_pre_held", heldL, 0);
    async_reset();
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b1);
    chk("t6_nL", nL, 1);
    chk("t6_lastL", lastL, 5);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b1);

    // Randomized bouncing keys, enable toggling and occasional resets.
    lenL = 0;
    lenR = 0;
    lvL = 1'b1;
    lvR = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (lenL == 0) begin lvL = $urandom_range(0, 1); lenL = $urandom_range(1, 9); end
      if (lenR == 0) begin lvR = $urandom_range(0, 1); lenR = $urandom_range(1, 9); end
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 599) == 0) async_reset();
      step(lvL, lvR, en);
      lenL--;
      lenR--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
